// File: rtl/exeu_alu_issue_pkg.sv
// Shared types for the EXU ALU issue block: ALU control codes, op types and operand selects.
package exeu_alu_issue_pkg;

  localparam int unsigned RegBus = 64;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OpForceAdd = 2'd0,
    OpImm      = 2'd1,
    OpReg      = 2'd2,
    OpRsvd     = 2'd3
  } op_type_e;

  typedef enum logic [1:0] {
    SrcARs1   = 2'd0,
    SrcAPc    = 2'd1,
    SrcAZero  = 2'd2,
    SrcAZero2 = 2'd3
  } src_a_sel_e;

  typedef enum logic [1:0] {
    SrcBRs2  = 2'd0,
    SrcBImm  = 2'd1,
    SrcBFour = 2'd2,
    SrcBZero = 2'd3
  } src_b_sel_e;

  function automatic logic is_shift(alu_ctrl_e ctrl);
    return (ctrl == AluSll) || (ctrl == AluSrl) || (ctrl == AluSra);
  endfunction

endpackage

// File: rtl/exeu_alu_issue_if.sv
// IDU payload, ALU operand and WBU result signals of the ALU issue block.
// master: the issue block itself; slave: the IDU/ALU/WBU environment around it.
interface exeu_alu_issue_if #(
  parameter int unsigned XLEN = exeu_alu_issue_pkg::RegBus
);
  logic            id_valid;
  logic            id_ready;
  logic [1:0]      id_op_type;
  logic [2:0]      id_funct3;
  logic            id_f7b5;
  logic            id_is_word;
  logic [1:0]      id_src_a_sel;
  logic [1:0]      id_src_b_sel;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1;
  logic [XLEN-1:0] id_rs2;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] alu_src_a;
  logic [XLEN-1:0] alu_src_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_out;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    input  id_valid, id_op_type, id_funct3, id_f7b5, id_is_word, id_src_a_sel, id_src_b_sel,
    input  id_pc, id_rs1, id_rs2, id_imm, id_rd, alu_out, wb_ready,
    output id_ready, alu_src_a, alu_src_b, alu_ctrl, wb_valid, wb_rd, wb_data
  );

  modport slave (
    output id_valid, id_op_type, id_funct3, id_f7b5, id_is_word, id_src_a_sel, id_src_b_sel,
    output id_pc, id_rs1, id_rs2, id_imm, id_rd, alu_out, wb_ready,
    input  id_ready, alu_src_a, alu_src_b, alu_ctrl, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/exeu_alu_decode.sv
// Combinational decode of (op_type, funct3, f7b5) into an ALU control code.
module exeu_alu_decode
  import exeu_alu_issue_pkg::*;
(
  input  logic [1:0] op_type_i,
  input  logic [2:0] funct3_i,
  input  logic       f7b5_i,
  output alu_ctrl_e  alu_ctrl_o
);

  op_type_e op_type;
  assign op_type = op_type_e'(op_type_i);

  always_comb begin
    alu_ctrl_o = AluAdd;
    if (op_type == OpImm || op_type == OpReg) begin
      unique case (funct3_i)
        3'b000:  alu_ctrl_o = (op_type == OpReg && f7b5_i) ? AluSub : AluAdd;
        3'b001:  alu_ctrl_o = AluSll;
        3'b010:  alu_ctrl_o = AluSlt;
        3'b011:  alu_ctrl_o = AluSltu;
        3'b100:  alu_ctrl_o = AluXor;
        3'b101:  alu_ctrl_o = f7b5_i ? AluSra : AluSrl;
        3'b110:  alu_ctrl_o = AluOr;
        default: alu_ctrl_o = AluAnd;
      endcase
    end
  end

endmodule

// File: rtl/exeu_alu_issue.sv
// Two-stage ALU issue/result pipeline between IDU, exeu_alu and WBU with valid/ready backpressure.
// Optional RV64 *W support is enabled by defining EXEU_WORD_OP_EN.
module exeu_alu_issue
  import exeu_alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = RegBus
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  exeu_alu_issue_if.master       bus
);

  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] src_a_q, src_a_d;
  logic [XLEN-1:0] src_b_q, src_b_d;
  alu_ctrl_e       ctrl_q, ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            s2_ready, s1_adv, id_ready, fire;
  logic [XLEN-1:0] op_a, op_b, result;
  alu_ctrl_e       dec_ctrl;

  assign s2_ready = !s2_valid_q || bus.wb_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign id_ready = !flush && (!s1_valid_q || s2_ready);
  assign fire     = bus.id_valid && id_ready;

  exeu_alu_decode u_decode (
    .op_type_i  (bus.id_op_type),
    .funct3_i   (bus.id_funct3),
    .f7b5_i     (bus.id_f7b5),
    .alu_ctrl_o (dec_ctrl)
  );

  always_comb begin
    unique case (src_a_sel_e'(bus.id_src_a_sel))
      SrcARs1: op_a = bus.id_rs1;
      SrcAPc:  op_a = bus.id_pc;
      default: op_a = '0;
    endcase
    unique case (src_b_sel_e'(bus.id_src_b_sel))
      SrcBRs2:  op_b = bus.id_rs2;
      SrcBImm:  op_b = bus.id_imm;
      SrcBFour: op_b = XLEN'(4);
      default:  op_b = '0;
    endcase
`ifdef EXEU_WORD_OP_EN
    // Word shifts only honour a 5-bit shift amount.
    if (bus.id_is_word && is_shift(dec_ctrl)) begin
      op_b = {{(XLEN-5){1'b0}}, op_b[4:0]};
    end
`endif
  end

`ifdef EXEU_WORD_OP_EN
  logic is_word_q, is_word_d;

  always_comb begin
    is_word_d = is_word_q;
    if (fire) begin
      is_word_d = bus.id_is_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_word_q <= 1'b0;
    end else begin
      is_word_q <= is_word_d;
    end
  end

  assign result = is_word_q ? {{(XLEN-32){bus.alu_out[31]}}, bus.alu_out[31:0]} : bus.alu_out;
`else
  logic unused_is_word;
  assign unused_is_word = bus.id_is_word;
  assign result = bus.alu_out;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (fire) begin
      s1_valid_d = 1'b1;
      src_a_d    = op_a;
      src_b_d    = op_b;
      ctrl_d     = dec_ctrl;
      rd_d       = bus.id_rd;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
    end else if (bus.wb_ready) begin
      s2_valid_d = 1'b0;
    end

    // A flush drops both stages but leaves the data registers untouched.
    if (s1_adv && !flush) begin
      wb_rd_d   = rd_q;
      wb_data_d = result;
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      ctrl_q     <= AluAdd;
      rd_q       <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.id_ready  = id_ready;
  assign bus.alu_src_a = src_a_q;
  assign bus.alu_src_b = src_b_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.wb_valid  = s2_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_exeu_alu_issue.sv
// Self-checking bench for exeu_alu_issue: behavioural ALU, result scoreboard, scenario tasks.
module tb_exeu_alu_issue;

  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t exp_next;

  always #5 clk = ~clk;

  exeu_alu_issue_if #(.XLEN(XLEN)) bus ();

  exeu_alu_issue #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Behavioural exeu_alu.
  always_comb begin
    case (bus.alu_ctrl)
      4'd0:    bus.alu_out = bus.alu_src_a + bus.alu_src_b;
      4'd1:    bus.alu_out = bus.alu_src_a - bus.alu_src_b;
      4'd2:    bus.alu_out = bus.alu_src_a << bus.alu_src_b[5:0];
      4'd3:    bus.alu_out = {63'd0, $signed(bus.alu_src_a) < $signed(bus.alu_src_b)};
      4'd4:    bus.alu_out = {63'd0, bus.alu_src_a < bus.alu_src_b};
      4'd5:    bus.alu_out = bus.alu_src_a ^ bus.alu_src_b;
      4'd6:    bus.alu_out = bus.alu_src_a >> bus.alu_src_b[5:0];
      4'd7:    bus.alu_out = $signed(bus.alu_src_a) >>> bus.alu_src_b[5:0];
      4'd8:    bus.alu_out = bus.alu_src_a | bus.alu_src_b;
      4'd9:    bus.alu_out = bus.alu_src_a & bus.alu_src_b;
      default: bus.alu_out = '0;
    endcase
  end

  // Scoreboard: push on id fire, pop on wb handshake; flush/rst drop everything in flight.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.wb_valid && bus.wb_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got rd=%0d data=%h, expected no result", bus.wb_rd,
                   bus.wb_data);
        end else begin
          e = sb.pop_front();
          if (bus.wb_rd !== e.rd || bus.wb_data !== e.data) begin
            errors++;
            $display("FAIL sb_result: got rd=%0d data=%h, expected rd=%0d data=%h", bus.wb_rd,
                     bus.wb_data, e.rd, e.data);
          end
        end
      end
      if (flush) sb.delete();
      else if (bus.id_valid && bus.id_ready) sb.push_back(exp_next);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic word, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [63:0] imm, input logic [4:0] rd, input logic [63:0] exp);
    bus.id_op_type   = op;
    bus.id_funct3    = f3;
    bus.id_f7b5      = f7;
    bus.id_is_word   = word;
    bus.id_src_a_sel = asel;
    bus.id_src_b_sel = bsel;
    bus.id_pc        = pc;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_imm       = imm;
    bus.id_rd        = rd;
    exp_next         = '{rd: rd, data: exp};
  endtask

  // Present an op and hold it until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic word, input logic [1:0] asel, input logic [1:0] bsel,
                       input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] imm, input logic [4:0] rd, input logic [63:0] exp);
    bit ok = 0;
    set_op(op, f3, f7, word, asel, bsel, pc, rs1, rs2, imm, rd, exp);
    bus.id_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.id_ready) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: id_ready=%b after 20 cycles, expected 1", bus.id_ready);
    end
    @(posedge clk); #1;
    bus.id_valid = 1'b0;
  endtask

  task automatic drain();
    bus.wb_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.id_valid = 1'b0;
    bus.wb_ready = 1'b1;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0, '0, '0, 5'd0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_wb: valid=%b rd=%0d data=%h, expected 0/0/0", bus.wb_valid,
               bus.wb_rd, bus.wb_data);
    end
    checks++;
    if (bus.alu_src_a !== 64'd0 || bus.alu_src_b !== 64'd0 || bus.alu_ctrl !== 4'd0) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h ctrl=%0d, expected 0/0/0", bus.alu_src_a,
               bus.alu_src_b, bus.alu_ctrl);
    end
    checks++;
    if (bus.id_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_id_ready: got %b, expected 1", bus.id_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sub_latency();
    issue(2'd2, 3'b000, 1'b1, 1'b0, 2'd0, 2'd0, 64'd0, 64'd10, 64'd3, 64'd0, 5'd1, 64'd7);
    @(negedge clk);
    checks++;
    if (bus.alu_ctrl !== 4'd1 || bus.alu_src_a !== 64'd10 || bus.alu_src_b !== 64'd3) begin
      errors++;
      $display("FAIL sub_issue: ctrl=%0d a=%h b=%h, expected 1/a/3", bus.alu_ctrl,
               bus.alu_src_a, bus.alu_src_b);
    end
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_early: wb_valid=%b at N+1, expected 0", bus.wb_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 64'd7) begin
      errors++;
      $display("FAIL sub_result: wb_valid=%b data=%h at N+2, expected 1/7", bus.wb_valid,
               bus.wb_data);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_sra_imm();
    issue(2'd1, 3'b101, 1'b1, 1'b0, 2'd0, 2'd1, 64'd0, 64'h8000_0000_0000_0000, 64'd0,
          64'd4, 5'd2, 64'hF800_0000_0000_0000);
    @(negedge clk);
    checks++;
    if (bus.alu_ctrl !== 4'd7) begin
      errors++;
      $display("FAIL sra_ctrl: got %0d, expected 7", bus.alu_ctrl);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_pc_plus4();
    issue(2'd0, 3'b110, 1'b1, 1'b0, 2'd1, 2'd2, 64'h8000_0000, 64'hDEAD, 64'hBEEF, 64'h55,
          5'd3, 64'h8000_0004);
    @(negedge clk);
    checks++;
    if (bus.alu_ctrl !== 4'd0 || bus.alu_src_b !== 64'd4) begin
      errors++;
      $display("FAIL pc_issue: ctrl=%0d b=%h, expected 0/4", bus.alu_ctrl, bus.alu_src_b);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_decode_table();
    logic [2:0]  f3_t  [11] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    logic        f7_t  [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  op_t  [11] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [3:0]  ctl_t [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    logic [63:0] res_t [11] = '{64'hFFFF_FFFF_FFFF_FFF3, 64'hFFFF_FFFF_FFFF_FFED,
                                64'hFFFF_FFFF_FFFF_FF80, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF3,
                                64'h1FFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                                64'hFFFF_FFFF_FFFF_FFF3, 64'd0, 64'hFFFF_FFFF_FFFF_FFF3};
    for (int i = 0; i < 11; i++) begin
      // OP uses rs2, OP-IMM uses imm; both carry 3 so results agree.
      issue(op_t[i], f3_t[i], f7_t[i], 1'b0, 2'd0, (op_t[i] == 2'd1) ? 2'd1 : 2'd0, 64'd0,
            64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 64'd3, 5'(i + 4), res_t[i]);
      @(negedge clk);
      checks++;
      if (bus.alu_ctrl !== ctl_t[i]) begin
        errors++;
        $display("FAIL decode_ctrl[%0d]: got %0d, expected %0d", i, bus.alu_ctrl, ctl_t[i]);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] held;
    bus.wb_ready = 1'b0;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'h100, 64'h1, '0, 5'd10, 64'h101);
    bus.id_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.id_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept0: id_ready=%b, expected 1", bus.id_ready);
    end
    @(posedge clk); #1;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'h200, 64'h2, '0, 5'd11, 64'h202);
    @(negedge clk);
    checks++;
    if (bus.id_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept1: id_ready=%b, expected 1", bus.id_ready);
    end
    @(posedge clk); #1;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'h300, 64'h3, '0, 5'd12, 64'h303);
    held = 64'h101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.id_ready !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_data !== held ||
          bus.wb_rd !== 5'd10) begin
        errors++;
        $display("FAIL b2b_stall[%0d]: id_ready=%b wb_valid=%b rd=%0d data=%h, expected 0/1/10/%h",
                 c, bus.id_ready, bus.wb_valid, bus.wb_rd, bus.wb_data, held);
      end
      @(posedge clk); #1;
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.id_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain_fill: id_ready=%b, expected 1", bus.id_ready);
    end
    @(posedge clk); #1;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'h400, 64'h4, '0, 5'd13, 64'h404);
    @(negedge clk);
    checks++;
    if (bus.id_ready !== 1'b1 || bus.wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stream: id_ready=%b wb_valid=%b, expected 1/1", bus.id_ready,
               bus.wb_valid);
    end
    @(posedge clk); #1;
    bus.id_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    bus.wb_ready = 1'b0;
    issue(2'd2, 3'd7, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'hFF, 64'h0F, '0, 5'd20, 64'h0F);
    issue(2'd2, 3'd6, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'hF0, 64'h0F, '0, 5'd21, 64'hFF);
    flush = 1'b1;
    set_op(2'd2, 3'd4, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'hAA, 64'hFF, '0, 5'd22, 64'h55);
    bus.id_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.id_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_id_ready: got %b, expected 0", bus.id_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_wb_valid: got %b, expected 0", bus.wb_valid);
    end
    @(posedge clk); #1;
    bus.id_valid = 1'b0;
    drain();
  endtask

  task automatic test_word();
`ifdef EXEU_WORD_OP_EN
    logic [63:0] exp = 64'hFFFF_FFFF_8000_0000;
`else
    logic [63:0] exp = 64'h0000_0000_8000_0000;
`endif
    issue(2'd2, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0, '0, 64'h7FFF_FFFF, 64'd1, '0, 5'd30, exp);
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b0;
    issue(2'd2, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'h1, 64'h4, '0, 5'd7, 64'h10);
    issue(2'd2, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, '0, 64'h1, 64'h5, '0, 5'd8, 64'h20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.alu_ctrl !== 4'd0 || bus.wb_data !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: wb_valid=%b ctrl=%0d data=%h, expected 0/0/0", bus.wb_valid,
               bus.alu_ctrl, bus.wb_data);
    end
    @(posedge clk); #1;
    drain();
    issue(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, '0, 64'd40, '0, 64'd2, 5'd9, 64'd42);
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_sub_latency();
    test_sra_imm();
    test_pc_plus4();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_word();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
